// File: rtl/execute_pkg.sv
// Shared definitions for the EX stage.
// ALU function codes, branch conditions and flag bit positions.
package execute_pkg;

  typedef enum logic [2:0] {
    FN_MOV = 3'b000,
    FN_ADD = 3'b001,
    FN_SUB = 3'b010,
    FN_AND = 3'b011,
    FN_OR  = 3'b100,
    FN_NOT = 3'b101,
    FN_SHL = 3'b110,
    FN_SHR = 3'b111
  } alu_fn_e;

  typedef enum logic [2:0] {
    BR_ALWAYS = 3'b000,
    BR_Z      = 3'b001,
    BR_N      = 3'b010,
    BR_C      = 3'b011
  } br_cond_e;

  localparam int FLG_Z = 0;
  localparam int FLG_N = 1;
  localparam int FLG_C = 2;

endpackage

// File: rtl/execute_stage_alu16.sv
// Combinational 16-bit ALU with Z/N/C outputs.
// cwrite_o marks the ops whose carry is meaningful.
module alu16
  import execute_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [2:0]        func_i,
  output logic [DATA_W-1:0] result_o,
  output logic              z_o,
  output logic              n_o,
  output logic              c_o,
  output logic              cwrite_o
);

  logic [3:0]      sh;
  logic [DATA_W:0] add_w;
  logic [DATA_W:0] sub_w;
  logic [DATA_W:0] shl_w;
  logic [DATA_W:0] shr_w;

  assign sh    = b_i[3:0];
  assign add_w = {1'b0, a_i} + {1'b0, b_i};
  assign sub_w = {1'b0, a_i} - {1'b0, b_i};
  // Guard bit catches the last bit shifted out; zero when sh==0
  assign shl_w = {1'b0, a_i} << sh;
  assign shr_w = {a_i, 1'b0} >> sh;

  always_comb begin
    result_o = a_i;
    c_o      = 1'b0;
    cwrite_o = 1'b0;
    unique case (func_i)
      FN_MOV: result_o = b_i;
      FN_ADD: begin
        result_o = add_w[DATA_W-1:0];
        c_o      = add_w[DATA_W];
        cwrite_o = 1'b1;
      end
      FN_SUB: begin
        result_o = sub_w[DATA_W-1:0];
        c_o      = sub_w[DATA_W];
        cwrite_o = 1'b1;
      end
      FN_AND: result_o = a_i & b_i;
      FN_OR:  result_o = a_i | b_i;
      FN_NOT: result_o = ~a_i;
      FN_SHL: begin
        result_o = shl_w[DATA_W-1:0];
        c_o      = shl_w[DATA_W];
        cwrite_o = 1'b1;
      end
      FN_SHR: begin
        result_o = shr_w[DATA_W:1];
        c_o      = shr_w[0];
        cwrite_o = 1'b1;
      end
      default: result_o = a_i;
    endcase
  end

  assign z_o = (result_o == '0);
  assign n_o = result_o[DATA_W-1];

endmodule

// File: rtl/execute_stage.sv
// EX stage: operand select, ALU, Z/N/C flag register and branch resolve.
// A taken conditional branch consumes (clears) the flag it tested.
module execute_stage
  import execute_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              aluOp,
  input  logic              branch,
  input  logic              aluSrc,
  input  logic [DATA_W-1:0] readData1,
  input  logic [DATA_W-1:0] readData2,
  input  logic [DATA_W-1:0] immediate,
  input  logic [2:0]        func,
  output logic [DATA_W-1:0] aluResult,
  output logic [2:0]        flag,
  output logic              branchTaken
);

  logic [DATA_W-1:0] op_b;
  logic [DATA_W-1:0] alu_res;
  logic              alu_z;
  logic              alu_n;
  logic              alu_c;
  logic              alu_cw;
  logic [2:0]        flag_d;
  logic [2:0]        flag_q;
  logic              taken;

  assign op_b = aluSrc ? immediate : readData2;

  alu16 #(
    .DATA_W(DATA_W)
  ) u_alu (
    .a_i     (readData1),
    .b_i     (op_b),
    .func_i  (func),
    .result_o(alu_res),
    .z_o     (alu_z),
    .n_o     (alu_n),
    .c_o     (alu_c),
    .cwrite_o(alu_cw)
  );

  always_comb begin
    taken = 1'b0;
    unique case (func)
      BR_ALWAYS: taken = 1'b1;
      BR_Z:      taken = flag_q[FLG_Z];
      BR_N:      taken = flag_q[FLG_N];
      BR_C:      taken = flag_q[FLG_C];
      default:   taken = 1'b0;
    endcase
  end

  always_comb begin
    aluResult = readData1;
    unique case (1'b1)
      branch:           aluResult = readData1;
      (!branch & aluOp): aluResult = alu_res;
      default:          aluResult = readData1;
    endcase
  end

  always_comb begin
    flag_d = flag_q;
    if (branch) begin
      if (taken) begin
        unique case (func)
          BR_Z:    flag_d[FLG_Z] = 1'b0;
          BR_N:    flag_d[FLG_N] = 1'b0;
          BR_C:    flag_d[FLG_C] = 1'b0;
          default: flag_d = flag_q;
        endcase
      end
    end else if (aluOp) begin
      flag_d[FLG_Z] = alu_z;
      flag_d[FLG_N] = alu_n;
      if (alu_cw) flag_d[FLG_C] = alu_c;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) flag_q <= 3'b000;
    else      flag_q <= flag_d;
  end

  assign flag        = flag_q;
  assign branchTaken = taken;

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU results, flags, branches, reset.
// Expected values are hand-computed constants.
module tb_execute_stage;

  logic        clk;
  logic        rst;
  logic        aluOp;
  logic        branch;
  logic        aluSrc;
  logic [15:0] readData1;
  logic [15:0] readData2;
  logic [15:0] immediate;
  logic [2:0]  func;
  logic [15:0] aluResult;
  logic [2:0]  flag;
  logic        branchTaken;

  int checks;
  int failures;

  execute_stage dut (
    .clk        (clk),
    .rst        (rst),
    .aluOp      (aluOp),
    .branch     (branch),
    .aluSrc     (aluSrc),
    .readData1  (readData1),
    .readData2  (readData2),
    .immediate  (immediate),
    .func       (func),
    .aluResult  (aluResult),
    .flag       (flag),
    .branchTaken(branchTaken)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic op, input logic br, input logic src,
                     input logic [15:0] a, input logic [15:0] b,
                     input logic [15:0] imm, input logic [2:0] f);
    aluOp     = op;
    branch    = br;
    aluSrc    = src;
    readData1 = a;
    readData2 = b;
    immediate = imm;
    func      = f;
    #1;
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    rst       = 1'b0;
    drv(0, 0, 0, 16'h0, 16'h0, 16'h0, 3'b000);
    #10;
    chk("reset_flag", {13'b0, flag}, 16'h0000);
    @(negedge clk);
    rst = 1'b1;

    // 1: ADD 0+1
    drv(1, 0, 0, 16'h0000, 16'h0001, 16'h0, 3'b001);
    chk("add01_res", aluResult, 16'h0001);
    tick();
    chk("add01_flag", {13'b0, flag}, 16'h0000);

    // 2: ADD wrap with carry
    drv(1, 0, 0, 16'hFFFF, 16'h0001, 16'h0, 3'b001);
    chk("addwrap_res", aluResult, 16'h0000);
    tick();
    chk("addwrap_flag", {13'b0, flag}, 16'h0005);

    // 3: SUB via immediate, then AND holds C
    drv(1, 0, 1, 16'h0001, 16'h1234, 16'h0002, 3'b010);
    chk("sub_res", aluResult, 16'hFFFF);
    tick();
    chk("sub_flag", {13'b0, flag}, 16'h0006);
    drv(1, 0, 0, 16'h00F0, 16'h0F00, 16'h0, 3'b011);
    chk("and_res", aluResult, 16'h0000);
    tick();
    chk("and_flag", {13'b0, flag}, 16'h0005);

    // pass-through and flag hold with aluOp=0
    drv(0, 0, 0, 16'hBEEF, 16'h0001, 16'h0, 3'b001);
    chk("pass_res", aluResult, 16'hBEEF);
    tick();
    chk("pass_flag", {13'b0, flag}, 16'h0005);

    // 4: branch on Z, taken then not taken
    drv(0, 1, 0, 16'h0040, 16'h0, 16'h0, 3'b001);
    chk("brz_taken", {15'b0, branchTaken}, 16'h0001);
    chk("brz_res", aluResult, 16'h0040);
    tick();
    chk("brz_flag", {13'b0, flag}, 16'h0004);
    chk("brz_again", {15'b0, branchTaken}, 16'h0000);
    tick();
    chk("brz_nt_flag", {13'b0, flag}, 16'h0004);

    // never / always / branch-wins-over-aluOp
    drv(1, 1, 0, 16'h0077, 16'h0001, 16'h0, 3'b111);
    chk("brnever", {15'b0, branchTaken}, 16'h0000);
    chk("brnever_res", aluResult, 16'h0077);
    tick();
    chk("brnever_flag", {13'b0, flag}, 16'h0004);
    drv(0, 1, 0, 16'h0080, 16'h0, 16'h0, 3'b000);
    chk("bralways", {15'b0, branchTaken}, 16'h0001);
    tick();
    chk("bralways_flag", {13'b0, flag}, 16'h0004);
    drv(0, 1, 0, 16'h0090, 16'h0, 16'h0, 3'b011);
    chk("brc_taken", {15'b0, branchTaken}, 16'h0001);
    tick();
    chk("brc_flag", {13'b0, flag}, 16'h0000);

    // other ALU ops, combinational only
    drv(1, 0, 0, 16'h1234, 16'hABCD, 16'h0, 3'b000);
    chk("mov_res", aluResult, 16'hABCD);
    drv(1, 0, 0, 16'h00F0, 16'h0F0F, 16'h0, 3'b100);
    chk("or_res", aluResult, 16'h0FFF);
    drv(1, 0, 0, 16'h00FF, 16'h0000, 16'h0, 3'b101);
    chk("not_res", aluResult, 16'hFF00);
    tick();
    chk("not_flag", {13'b0, flag}, 16'h0002);
    drv(0, 1, 0, 16'h0010, 16'h0, 16'h0, 3'b010);
    chk("brn_taken", {15'b0, branchTaken}, 16'h0001);
    tick();
    chk("brn_flag", {13'b0, flag}, 16'h0000);
    drv(1, 0, 0, 16'h0005, 16'h0005, 16'h0, 3'b010);
    chk("subeq_res", aluResult, 16'h0000);
    tick();
    chk("subeq_flag", {13'b0, flag}, 16'h0001);

    // 5: shifts
    drv(1, 0, 0, 16'h8001, 16'h0001, 16'h0, 3'b110);
    chk("shl_res", aluResult, 16'h0002);
    tick();
    chk("shl_flag", {13'b0, flag}, 16'h0004);
    drv(1, 0, 0, 16'h0003, 16'h0001, 16'h0, 3'b111);
    chk("shr_res", aluResult, 16'h0001);
    tick();
    chk("shr_flag", {13'b0, flag}, 16'h0004);
    drv(1, 0, 0, 16'h8000, 16'h0000, 16'h0, 3'b110);
    chk("shl0_res", aluResult, 16'h8000);
    tick();
    chk("shl0_flag", {13'b0, flag}, 16'h0002);
    drv(1, 0, 0, 16'h8000, 16'h0010, 16'h0, 3'b111);
    chk("shr16_res", aluResult, 16'h8000);
    drv(1, 0, 0, 16'h4000, 16'h000F, 16'h0, 3'b111);
    chk("shr15_res", aluResult, 16'h0000);
    tick();
    chk("shr15_flag", {13'b0, flag}, 16'h0005);

    // 6: async reset between edges
    drv(1, 0, 0, 16'hFFFF, 16'h0001, 16'h0, 3'b001);
    tick();
    chk("prerst_flag", {13'b0, flag}, 16'h0005);
    #1;
    rst = 1'b0;
    #1;
    chk("rst_async", {13'b0, flag}, 16'h0000);
    chk("rst_res", aluResult, 16'h0000);
    tick();
    chk("rst_hold", {13'b0, flag}, 16'h0000);
    drv(0, 1, 0, 16'h0020, 16'h0, 16'h0, 3'b001);
    chk("rst_brz", {15'b0, branchTaken}, 16'h0000);
    drv(0, 1, 0, 16'h0020, 16'h0, 16'h0, 3'b000);
    chk("rst_bralw", {15'b0, branchTaken}, 16'h0001);
    @(negedge clk);
    rst = 1'b1;
    drv(1, 0, 0, 16'h0000, 16'h8000, 16'h0, 3'b001);
    tick();
    chk("post_rst", {13'b0, flag}, 16'h0002);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
